// File: rtl/t05_bit_packer.sv
// Serial MSB-first bit packer for the Huffman encoder: packs bits into WORD_W words and
// writes them to SRAM through a one-deep hold register with a req/ack handshake.
module t05_bit_packer #(
  parameter int                WORD_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              flush,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              overflow,
  output logic              done,
  output logic [15:0]       bit_count
);

  localparam int                CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_W / 8);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_PAD   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_v;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf;
  logic [15:0]       r_bcnt;

  logic              w_run;
  logic              w_take;
  logic [WORD_W-1:0] w_sr_nx;
  logic              w_cmpl;
  logic              w_ack;
  logic              w_hold_free;
  logic              w_cmpl_ld;
  logic              w_drop;
  logic              w_pad_ld;
  logic [CNT_W:0]    w_pad_sh;
  logic [WORD_W-1:0] w_pad_word;
  logic [CNT_W-1:0]  w_cnt_nx;

  assign w_run       = (r_state == S_RUN);
  assign w_take      = w_run && bit_valid;
  assign w_sr_nx     = {r_sr[WORD_W-2:0], bit_in};
  assign w_cmpl      = w_take && (r_cnt == CNT_LAST);
  assign w_ack       = r_hold_v && wr_ack;
  // An ack this cycle frees the hold register in time for a same-cycle reload.
  assign w_hold_free = !r_hold_v || wr_ack;
  assign w_cmpl_ld   = w_cmpl && w_hold_free;
  assign w_drop      = w_cmpl && !w_hold_free;
  assign w_pad_ld    = (r_state == S_PAD) && w_hold_free;
  assign w_pad_sh    = (CNT_W+1)'(WORD_W) - {1'b0, r_cnt};
  assign w_pad_word  = r_sr << w_pad_sh;
  assign w_cnt_nx    = w_take ? (w_cmpl ? '0 : r_cnt + CNT_W'(1)) : r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_RUN;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_hold_v <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_ovf    <= 1'b0;
      r_bcnt   <= '0;
    end else begin
      if (w_take) begin
        r_sr   <= w_sr_nx;
        r_bcnt <= r_bcnt + 16'd1;
      end
      r_cnt <= w_pad_ld ? '0 : w_cnt_nx;

      if (w_cmpl_ld) begin
        r_hold   <= w_sr_nx;
        r_hold_v <= 1'b1;
      end else if (w_pad_ld) begin
        r_hold   <= w_pad_word;
        r_hold_v <= 1'b1;
      end else if (w_ack) begin
        r_hold_v <= 1'b0;
      end

      if (w_ack) r_addr <= r_addr + ADDR_STEP;
      if (w_drop || (bit_valid && !w_run)) r_ovf <= 1'b1;

      // Flush decision uses the count after any same-cycle bit has been packed.
      case (r_state)
        S_RUN:   if (flush) r_state <= (w_cnt_nx != '0) ? S_PAD : S_DRAIN;
        S_PAD:   if (w_pad_ld) r_state <= S_DRAIN;
        S_DRAIN: if (!r_hold_v) r_state <= S_DONE;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign wr_req    = r_hold_v;
  assign wr_data   = r_hold;
  assign wr_addr   = r_addr;
  assign busy      = r_hold_v || !w_run;
  assign overflow  = r_ovf;
  assign done      = (r_state == S_DONE);
  assign bit_count = r_bcnt;

endmodule

// File: tb/tb_t05_bit_packer.sv
// Self-checking bench for t05_bit_packer: vector table, directed corner sequences and a
// randomized segment run checked against a queue-based bit-stream model.
module tb_t05_bit_packer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        bit_in = 1'b0, bit_valid = 1'b0, flush = 1'b0;
  logic        wr_req, wr_ack;
  logic [31:0] wr_addr, wr_data;
  logic        busy, overflow, done;
  logic [15:0] bit_count;

  logic        auto_ack = 1'b0, ack_auto = 1'b0, ack_man = 1'b0;
  int          ack_dly = 1, wcnt = 0;
  int          checks = 0, errors = 0;
  int          done_cnt = 0;
  logic [31:0] obs_addr[$], obs_data[$];

  assign wr_ack = auto_ack ? ack_auto : ack_man;

  t05_bit_packer #(.WORD_W(32), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .nrst(nrst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .overflow(overflow), .done(done), .bit_count(bit_count));

  always #5 clk = ~clk;

  // SRAM responder: acks after ack_dly stalled cycles and logs what it accepted.
  always @(negedge clk) begin
    if (!auto_ack) begin
      ack_auto = 1'b0;
      wcnt = 0;
    end else if (ack_auto) begin
      ack_auto = 1'b0;
    end else if (wr_req) begin
      if (wcnt >= ack_dly) begin
        ack_auto = 1'b1;
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
        wcnt = 0;
      end else wcnt++;
    end
  end

  always @(negedge clk) if (nrst && done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write request must hold address and data steady until acknowledged.
  logic        pe_req = 1'b0, pe_ack = 1'b0;
  logic [31:0] pe_addr = '0, pe_data = '0;
  always @(posedge clk) begin
    pe_req  <= wr_req;
    pe_ack  <= wr_ack;
    pe_addr <= wr_addr;
    pe_data <= wr_data;
  end
  always @(negedge clk) begin
    if (nrst && pe_req && !pe_ack && wr_req) begin
      chk("stable_addr", wr_addr, pe_addr);
      chk("stable_data", wr_data, pe_data);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  wr_req, 0);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"},  overflow, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bcnt"}, bit_count, 0);
  endtask

  task automatic do_reset();
    nrst = 1'b0; bit_valid = 0; flush = 0; bit_in = 0; ack_man = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives bits MSB-first from the n LSBs of pat, one per cycle; optional flush on last.
  task automatic send_bits(input logic [31:0] pat, input int n, input bit fl_last);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in = pat[i]; bit_valid = 1'b1; flush = fl_last && (i == 0);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({name, "_done_seen"}, ok, 1);
    @(posedge clk); #1;
  endtask

  // Reference model: the stream as a bit queue; 32 bits make a word, flush pads zeros.
  bit          mq[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] maddr = 0;

  task automatic model_emit();
    logic [31:0] w = 0;
    for (int k = 0; k < 32; k++) w = {w[30:0], mq[k]};
    mq.delete();
    exp_data.push_back(w);
    exp_addr.push_back(maddr);
    maddr += 32'd4;
  endtask

  task automatic model_bit(input bit b);
    mq.push_back(b);
    if (mq.size() == 32) model_emit();
  endtask

  task automatic model_flush();
    if (mq.size() > 0) begin
      while (mq.size() < 32) mq.push_back(1'b0);
      model_emit();
    end
  endtask

  typedef struct {
    logic [31:0] pat;
    int          nb;
    bit          fl_last;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int base, dbase, total;
    logic [31:0] b32;

    vt[0] = '{32'hDEADBEEF, 32, 1'b0, 32'hDEADBEEF};
    vt[1] = '{32'h00000141,  9, 1'b0, 32'hA0800000};
    vt[2] = '{32'h00000001,  1, 1'b0, 32'h80000000};
    vt[3] = '{32'h7FFFFFFF, 31, 1'b1, 32'hFFFFFFFE};
    vt[4] = '{32'hCAFEF00D, 32, 1'b1, 32'hCAFEF00D};
    vt[5] = '{32'h00001234, 16, 1'b0, 32'h12340000};

    #2;
    chk_reset_vals("reset");
    do_reset();

    // Table: one segment per vector, each from reset, responder acks one cycle late.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      auto_ack = 1'b1; ack_dly = 1;
      base = obs_data.size(); dbase = done_cnt;
      send_bits(vt[v].pat, vt[v].nb, vt[v].fl_last);
      if (!vt[v].fl_last) pulse_flush();
      wait_done($sformatf("v%0d", v));
      repeat (3) @(posedge clk); #1;
      chk($sformatf("v%0d_nwr", v), obs_data.size() - base, 1);
      if (obs_data.size() > base) begin
        chk($sformatf("v%0d_data", v), obs_data[base], vt[v].exp);
        chk($sformatf("v%0d_addr", v), obs_addr[base], 0);
      end
      chk($sformatf("v%0d_done_cnt", v), done_cnt - dbase, 1);
      chk($sformatf("v%0d_next_addr", v), wr_addr, 4);
      chk($sformatf("v%0d_bcnt", v), bit_count, vt[v].nb);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_ovf", v), overflow, 0);
    end

    // Stalled SRAM: second word is dropped, first one survives.
    do_reset();
    auto_ack = 1'b0;
    send_bits(32'hFFFFFFFF, 32, 0);
    send_bits(32'hFFFFFFFF, 32, 0);
    @(negedge clk);
    chk("t3_req", wr_req, 1);
    chk("t3_data", wr_data, 32'hFFFFFFFF);
    chk("t3_addr", wr_addr, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_bcnt", bit_count, 64);
    base = obs_data.size();
    @(posedge clk); #1;
    auto_ack = 1'b1; ack_dly = 0;
    repeat (10) @(posedge clk); #1;
    chk("t3_nwr", obs_data.size() - base, 1);
    chk("t3_addr_after", wr_addr, 4);
    chk("t3_ovf_sticky", overflow, 1);

    // Word 2 completes in the very cycle word 1 is acknowledged.
    do_reset();
    auto_ack = 1'b0;
    send_bits(32'h11223344, 32, 0);
    send_bits(32'h55667788 >> 1, 31, 0);
    chk("t4_w1_data", wr_data, 32'h11223344);
    chk("t4_w1_addr", wr_addr, 0);
    bit_in = 1'b0; bit_valid = 1'b1; ack_man = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; ack_man = 1'b0;
    chk("t4_req", wr_req, 1);
    chk("t4_w2_data", wr_data, 32'h55667788);
    chk("t4_w2_addr", wr_addr, 4);
    chk("t4_ovf", overflow, 0);
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    chk("t4_req_low", wr_req, 0);
    chk("t4_addr_end", wr_addr, 8);

    // Flush with nothing buffered: done two cycles later, never a request.
    do_reset();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_done_c1", done, 0);
    chk("t5_busy_c1", busy, 1);
    chk("t5_req_c1", wr_req, 0);
    @(negedge clk);
    chk("t5_done_c2", done, 1);
    chk("t5_req_c2", wr_req, 0);
    @(negedge clk);
    chk("t5_done_c3", done, 0);
    chk("t5_busy_c3", busy, 0);
    @(posedge clk); #1;

    // Reset mid-operation with a request outstanding.
    do_reset();
    auto_ack = 1'b0;
    send_bits(32'hDEADBEEF, 32, 0);
    send_bits(32'h000ABCDE, 20, 0);
    chk("t6_pending", wr_req, 1);
    #2 nrst = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;
    auto_ack = 1'b1; ack_dly = 1;
    base = obs_data.size();
    send_bits(32'h0F0F1234, 32, 0);
    repeat (8) @(posedge clk); #1;
    chk("t6_nwr", obs_data.size() - base, 1);
    if (obs_data.size() > base) begin
      chk("t6_addr", obs_addr[base], 0);
      chk("t6_data", obs_data[base], 32'h0F0F1234);
    end

    // Randomized segments with gaps and varying ack latency against the model.
    do_reset();
    auto_ack = 1'b1;
    base = obs_data.size();
    mq.delete(); exp_addr.delete(); exp_data.delete(); maddr = 0; total = 0;
    for (int s = 0; s < 10; s++) begin
      int nb;
      bit fl;
      nb = $urandom_range(1, 90);
      fl = $urandom_range(0, 1);
      ack_dly = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        b32 = $urandom;
        send_bits(b32, 1, fl && (i == nb - 1));
        model_bit(b32[0]);
      end
      total += nb;
      if (!fl) pulse_flush();
      model_flush();
      wait_done($sformatf("rnd%0d", s));
    end
    repeat (5) @(posedge clk); #1;
    chk("rnd_nwr", obs_data.size() - base, exp_data.size());
    for (int k = 0; k < exp_data.size(); k++) begin
      if (base + k < obs_data.size()) begin
        chk($sformatf("rnd_data%0d", k), obs_data[base+k], exp_data[k]);
        chk($sformatf("rnd_addr%0d", k), obs_addr[base+k], exp_addr[k]);
      end
    end
    chk("rnd_bcnt", bit_count, total[15:0]);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
